// File: rtl/divider_bank.sv
// divider_bank: a bank of independent programmable clock dividers.
//
// Each channel counts clk cycles up to its active divisor. At every wrap it
// emits a one-cycle tick and starts a square wave that is high for div>>1
// cycles. A divisor written through the shared write port is held as
// pending and is only applied at a period boundary (wrap, sync or disable),
// so a period is never truncated or stretched.
//
// Ports
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset
//   en       in   [N_CH] per-channel run enable
//   sync     in   phase-align strobe for all enabled channels
//   wr_en    in   divisor write strobe
//   wr_ch    in   [3] target channel of the write
//   wr_div   in   [CNT_W] new divisor (period in clk cycles, >= 2)
//   tick     out  [N_CH] one-cycle pulse per channel period
//   sq_out   out  [N_CH] per-channel square wave, rising with tick
//   div_pend out  [N_CH] channel holds a written divisor not yet applied
//   wr_err   out  one-cycle pulse after a rejected write
module divider_bank #(
    parameter int                      N_CH     = 3,
    parameter int                      CNT_W    = 32,
    parameter logic [N_CH*CNT_W-1:0]   DIV_INIT = {N_CH{CNT_W'(100)}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH-1:0]   en,
    input  logic              sync,
    input  logic              wr_en,
    input  logic [2:0]        wr_ch,
    input  logic [CNT_W-1:0]  wr_div,
    output logic [N_CH-1:0]   tick,
    output logic [N_CH-1:0]   sq_out,
    output logic [N_CH-1:0]   div_pend,
    output logic              wr_err
);

    logic [CNT_W-1:0] cnt_q  [N_CH];
    logic [CNT_W-1:0] cnt_d  [N_CH];
    logic [CNT_W-1:0] div_q  [N_CH];
    logic [CNT_W-1:0] div_d  [N_CH];
    logic [CNT_W-1:0] pdiv_q [N_CH];
    logic [CNT_W-1:0] pdiv_d [N_CH];
    logic [N_CH-1:0]  pend_q, pend_d;
    logic [N_CH-1:0]  tick_q, tick_d;
    logic [N_CH-1:0]  sq_q, sq_d;
    logic             wr_err_q, wr_err_d;

    logic [N_CH-1:0]  wrap;
    logic [N_CH-1:0]  half;
    logic             wr_ok;

    // Channel index is widened by one bit so N_CH = 8 compares correctly.
    assign wr_ok = wr_en && ({1'b0, wr_ch} < 4'(N_CH)) && (wr_div > CNT_W'(1));

    for (genvar g = 0; g < N_CH; g++) begin : g_cmp
        assign wrap[g] = (cnt_q[g] == div_q[g] - CNT_W'(1));
        // Last high cycle of the square wave; it drops on the following edge.
        assign half[g] = (cnt_q[g] == (div_q[g] >> 1) - CNT_W'(1));
    end

    always_comb begin
        wr_err_d = wr_en && !wr_ok;
        pend_d   = pend_q;
        tick_d   = '0;
        sq_d     = sq_q;
        for (int i = 0; i < N_CH; i++) begin
            cnt_d[i]  = cnt_q[i];
            div_d[i]  = div_q[i];
            pdiv_d[i] = pdiv_q[i];

            if (!en[i] || sync || wrap[i]) begin
                // Period boundary: the only place the active divisor may change.
                if (pend_q[i]) begin
                    div_d[i]  = pdiv_q[i];
                    pend_d[i] = 1'b0;
                end
                cnt_d[i] = '0;
                if (en[i]) begin
                    tick_d[i] = 1'b1;
                    sq_d[i]   = 1'b1;
                end else begin
                    sq_d[i]   = 1'b0;
                end
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
                if (half[i]) sq_d[i] = 1'b0;
            end

            // Applied after the boundary logic so a coincident write waits
            // for the next boundary instead of affecting this one.
            if (wr_ok && (wr_ch == 3'(i))) begin
                pdiv_d[i] = wr_div;
                pend_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i]  <= '0;
                div_q[i]  <= DIV_INIT[i*CNT_W +: CNT_W];
                pdiv_q[i] <= '0;
            end
            pend_q   <= '0;
            tick_q   <= '0;
            sq_q     <= '0;
            wr_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i]  <= cnt_d[i];
                div_q[i]  <= div_d[i];
                pdiv_q[i] <= pdiv_d[i];
            end
            pend_q   <= pend_d;
            tick_q   <= tick_d;
            sq_q     <= sq_d;
            wr_err_q <= wr_err_d;
        end
    end

    assign tick     = tick_q;
    assign sq_out   = sq_q;
    assign div_pend = pend_q;
    assign wr_err   = wr_err_q;

endmodule

// File: tb/tb_divider_bank.sv
module tb_divider_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  en;
    logic        sync;
    logic        wr_en;
    logic [2:0]  wr_ch;
    logic [7:0]  wr_div;
    logic [2:0]  tick;
    logic [2:0]  sq_out;
    logic [2:0]  div_pend;
    logic        wr_err;

    int total = 0;
    int bad   = 0;

    divider_bank #(
        .N_CH(3),
        .CNT_W(8),
        .DIV_INIT({8'd4, 8'd4, 8'd4})
    ) dut (
        .clk(clk), .rst(rst), .en(en), .sync(sync),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_div(wr_div),
        .tick(tick), .sq_out(sq_out), .div_pend(div_pend), .wr_err(wr_err)
    );

    always #5 clk = ~clk;

    // Advance one rising edge; inputs change and outputs are sampled 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 3'b000; sync = 1'b0;
        wr_en = 1'b0; wr_ch = 3'd0; wr_div = 8'd0;
        step(); step();
        total++;
        if ({tick, sq_out, div_pend, wr_err} !== 10'b0) begin
            bad++;
            $display("FAIL reset_outputs got=%b want=0", {tick, sq_out, div_pend, wr_err});
        end
    endtask

    // All channels at div 4: tick at k=4,8,12; sq high k=4,5 low 6,7.
    task automatic test_basic();
        logic [2:0] et, es;
        rst = 1'b0; en = 3'b111;
        for (int k = 1; k <= 12; k++) begin
            step();
            et = (k % 4 == 0) ? 3'b111 : 3'b000;
            es = (k >= 4 && (k % 4) < 2) ? 3'b111 : 3'b000;
            total++;
            if (tick !== et) begin
                bad++; $display("FAIL basic_tick k=%0d got=%b want=%b", k, tick, et);
            end
            total++;
            if (sq_out !== es) begin
                bad++; $display("FAIL basic_sq k=%0d got=%b want=%b", k, sq_out, es);
            end
        end
    endtask

    // Write div 6 to channel 0 while its cnt=1; applied at the k=16 wrap.
    task automatic test_write_apply();
        logic et0, es0, ep0, et1;
        step();  // k=13, cnt0=1
        wr_en = 1'b1; wr_ch = 3'd0; wr_div = 8'd6;
        for (int k = 14; k <= 28; k++) begin
            step();
            wr_en = 1'b0;
            ep0 = (k < 16);
            et0 = (k >= 16) && ((k - 16) % 6 == 0);
            es0 = (k >= 16) && ((k - 16) % 6 < 3);
            et1 = (k % 4 == 0);
            total++;
            if (div_pend[0] !== ep0) begin
                bad++; $display("FAIL wr_pend k=%0d got=%b want=%b", k, div_pend[0], ep0);
            end
            total++;
            if (tick[0] !== et0) begin
                bad++; $display("FAIL wr_tick0 k=%0d got=%b want=%b", k, tick[0], et0);
            end
            total++;
            if (sq_out[0] !== es0) begin
                bad++; $display("FAIL wr_sq0 k=%0d got=%b want=%b", k, sq_out[0], es0);
            end
            total++;
            if (tick[1] !== et1) begin
                bad++; $display("FAIL wr_tick1 k=%0d got=%b want=%b", k, tick[1], et1);
            end
        end
    endtask

    task automatic test_bad_write();
        wr_en = 1'b1; wr_ch = 3'd1; wr_div = 8'd1;
        step();
        wr_en = 1'b0;
        total++;
        if ({wr_err, div_pend} !== 4'b1000) begin
            bad++; $display("FAIL badwr_div1 got=%b want=1000", {wr_err, div_pend});
        end
        step();
        total++;
        if (wr_err !== 1'b0) begin
            bad++; $display("FAIL badwr_div1_clear got=%b want=0", wr_err);
        end
        wr_en = 1'b1; wr_ch = 3'd5; wr_div = 8'd6;
        step();
        wr_en = 1'b0;
        total++;
        if ({wr_err, div_pend} !== 4'b1000) begin
            bad++; $display("FAIL badwr_ch5 got=%b want=1000", {wr_err, div_pend});
        end
        step();
        total++;
        if (wr_err !== 1'b0) begin
            bad++; $display("FAIL badwr_ch5_clear got=%b want=0", wr_err);
        end
    endtask

    // Load divisors 4/5/7, sync, then channels resume their own periods;
    // then a write coincident with a channel 1 wrap.
    task automatic test_sync_and_coincident();
        logic [2:0] et, es;
        logic ep1;
        wr_en = 1'b1; wr_ch = 3'd0; wr_div = 8'd4; step();
        wr_ch = 3'd1; wr_div = 8'd5; step();
        wr_ch = 3'd2; wr_div = 8'd7; step();
        wr_en = 1'b0; step();
        sync = 1'b1;
        step();
        sync = 1'b0;
        total++;
        if ({tick, sq_out, div_pend} !== 9'b111_111_000) begin
            bad++; $display("FAIL sync_edge got=%b want=111111000", {tick, sq_out, div_pend});
        end
        for (int s = 1; s <= 14; s++) begin
            step();
            et = {s % 7 == 0, s % 5 == 0, s % 4 == 0};
            es = {(s % 7) < 3, (s % 5) < 2, (s % 4) < 2};
            total++;
            if (tick !== et) begin
                bad++; $display("FAIL sync_tick s=%0d got=%b want=%b", s, tick, et);
            end
            total++;
            if (sq_out !== es) begin
                bad++; $display("FAIL sync_sq s=%0d got=%b want=%b", s, sq_out, es);
            end
        end
        // cnt1 = 4 now: this write lands on the wrap edge of channel 1.
        wr_en = 1'b1; wr_ch = 3'd1; wr_div = 8'd3;
        for (int s = 15; s <= 27; s++) begin
            step();
            wr_en = 1'b0;
            et[1] = (s == 15) || (s == 20) || (s == 23) || (s == 26);
            ep1 = (s < 20);
            total++;
            if (tick[1] !== et[1]) begin
                bad++; $display("FAIL coin_tick1 s=%0d got=%b want=%b", s, tick[1], et[1]);
            end
            total++;
            if (div_pend[1] !== ep1) begin
                bad++; $display("FAIL coin_pend1 s=%0d got=%b want=%b", s, div_pend[1], ep1);
            end
        end
    endtask

    // Disabled channel: outputs low, a write is applied without waiting.
    task automatic test_disable();
        logic e;
        en = 3'b110;
        step();
        total++;
        if ({tick[0], sq_out[0]} !== 2'b00) begin
            bad++; $display("FAIL dis_out got=%b want=00", {tick[0], sq_out[0]});
        end
        wr_en = 1'b1; wr_ch = 3'd0; wr_div = 8'd2;
        step();
        wr_en = 1'b0;
        total++;
        if (div_pend[0] !== 1'b1) begin
            bad++; $display("FAIL dis_pend_set got=%b want=1", div_pend[0]);
        end
        step();
        total++;
        if (div_pend[0] !== 1'b0) begin
            bad++; $display("FAIL dis_pend_applied got=%b want=0", div_pend[0]);
        end
        en = 3'b111;
        for (int k = 1; k <= 6; k++) begin
            step();
            e = (k % 2 == 0);
            total++;
            if ({tick[0], sq_out[0]} !== {e, e}) begin
                bad++; $display("FAIL dis_reen k=%0d got=%b want=%b", k, {tick[0], sq_out[0]}, {e, e});
            end
        end
    endtask

    // Reset mid-period with a pending write on channel 2.
    task automatic test_reset_mid();
        logic [2:0] et;
        wr_en = 1'b1; wr_ch = 3'd2; wr_div = 8'd9;
        step();
        wr_en = 1'b0;
        total++;
        if (div_pend[2] !== 1'b1) begin
            bad++; $display("FAIL rmid_pend got=%b want=1", div_pend[2]);
        end
        step();
        rst = 1'b1;
        step();
        total++;
        if ({tick, sq_out, div_pend, wr_err} !== 10'b0) begin
            bad++; $display("FAIL rmid_outputs got=%b want=0", {tick, sq_out, div_pend, wr_err});
        end
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            et = (k % 4 == 0) ? 3'b111 : 3'b000;
            total++;
            if (tick !== et) begin
                bad++; $display("FAIL rmid_tick k=%0d got=%b want=%b", k, tick, et);
            end
            total++;
            if (div_pend !== 3'b000) begin
                bad++; $display("FAIL rmid_pend_after k=%0d got=%b want=000", k, div_pend);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_write_apply();
        test_bad_write();
        test_sync_and_coincident();
        test_disable();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/divider_bank.md
DIVIDER_BANK -- requirements
Module: divider_bank

Interface
REQ-001 The block SHALL have parameter N_CH, default 3: number of independent divider channels (1..8).
REQ-002 The block SHALL have parameter CNT_W, default 32: width of each channel's counter and divisor.
REQ-003 The block SHALL have parameter DIV_INIT, default {N_CH{CNT_W'd100}}: packed per-channel reset divisors; channel i uses bits [i*CNT_W +: CNT_W], each >=2.
REQ-004 The block SHALL have port clk  input  1: system clock; all logic on its rising edge.
REQ-005 The block SHALL have port rst  input  1: reset, synchronous, active-high.
REQ-006 The block SHALL have port en  input  N_CH: per-channel run enable.
REQ-007 The block SHALL have port sync  input  1: single-cycle phase-align strobe for all enabled channels.
REQ-008 The block SHALL have port wr_en  input  1: divisor write strobe.
REQ-009 The block SHALL have port wr_ch  input  3: target channel of the write.
REQ-010 The block SHALL have port wr_div  input  CNT_W: new divisor, period in clk cycles.
REQ-011 The block SHALL have port tick  output  N_CH: one-cycle pulse per channel period.
REQ-012 The block SHALL have port sq_out  output  N_CH: per-channel square wave, rising with tick.
REQ-013 The block SHALL have port div_pend  output  N_CH: channel has a written divisor not yet applied.
REQ-014 The block SHALL have port wr_err  output  1: one-cycle pulse flagging a rejected write.

Function
REQ-015 All outputs SHALL be registered; per channel the block SHALL hold cnt, div (active), pdiv (pending), pend.
REQ-016 Enabled channel, cnt != div-1: cnt SHALL increment by 1; tick SHALL be 0 next cycle.
REQ-017 Enabled channel, cnt == div-1 (wrap): cnt SHALL become 0, tick SHALL be 1 next cycle, and if pend=1 then div<=pdiv, pend<=0.
REQ-018 sq_out SHALL be set in the same cycle tick is 1, and SHALL be cleared in the cycle after cnt == (div>>1)-1, giving div>>1 cycles high and div-(div>>1) low per period.
REQ-019 After reset, enable, or disable-enable, tick SHALL first assert exactly div cycles after the first enabled cycle; sq_out SHALL stay 0 until that tick.
REQ-020 Disabled channel (en[i]=0): cnt, tick and sq_out SHALL be 0 next cycle; a pending divisor SHALL be applied immediately (div<=pdiv, pend<=0).
REQ-021 sync=1 SHALL, for every enabled channel, force cnt=0, tick=1, sq_out=1 next cycle and apply any pending divisor; disabled channels SHALL ignore sync.
REQ-022 A write with wr_ch<N_CH and wr_div>=2 SHALL set pdiv and pend=1 next cycle; a later write before application SHALL overwrite pdiv.
REQ-023 A write with wr_ch>=N_CH or wr_div<2 SHALL change no state and SHALL pulse wr_err=1 for exactly one cycle, the cycle after the write.
REQ-024 A write in the same cycle as a wrap or sync on that channel SHALL NOT affect that wrap/sync; it SHALL apply at the next wrap, sync or disable.
REQ-025 Priority per channel SHALL be rst > disable > sync > wrap > increment.
REQ-026 The active divisor SHALL never change except at a wrap, sync, disable or reset, so no truncated or stretched period SHALL appear on tick or sq_out.
REQ-027 Channels SHALL be fully independent except for the shared sync and write port.

Reset
REQ-028 While rst=1: cnt=0, div=DIV_INIT slice, pdiv=0, pend=0, tick=0, sq_out=0, div_pend=0, wr_err=0, in the cycle after rst is sampled high.
REQ-029 rst asserted mid-period SHALL discard pending writes and restart all channels per REQ-019 after release.

Verification
REQ-030 DIV_INIT all 4, en=3'b111 after reset -> tick on each channel in cycles 4, 8, 12...; sq_out high cycles 4-5, low 6-7.
REQ-031 Channel 0 running div=4, write wr_div=6 at cnt=1 -> div_pend[0]=1 until next wrap; following periods are 6 cycles, sq_out 3 high/3 low.
REQ-032 Write wr_div=1, then wr_ch=5 (N_CH=3) -> wr_err pulses one cycle each; divisors, div_pend unchanged.
REQ-033 Channels at div 4, 5, 7 free-running, sync pulse -> all three tick and raise sq_out in the same next cycle, then resume own periods.
REQ-034 Write coincident with channel 1 wrap -> wrap uses old divisor; new divisor takes effect from the subsequent wrap.
REQ-035 rst asserted with pend=1 on channel 2 and cnt mid-period -> all outputs 0, pend cleared, div back to DIV_INIT; first tick div cycles after release.
